jtag_dmi_tap_sampled: RTL

// - JTAG target end of the debug link: the debug-transport TAP that the bench JTAG driver talks to.
// - Oversamples tck/tms/tdi in the clk_i domain and runs the IEEE 1149.1 TAP FSM.
// - Instructions: IDCODE, BYPASS, DTMCS and DMIACCESS.
// - Converts DMIACCESS Update-DR into a valid/ready DMI request toward the debug module.
// - Returns the DMI response on the next Capture-DR.

---
 rtl/jtag_dmi_tap_sampled.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_dmi_tap_sampled.sv
// jtag_dmi_tap_sampled: debug-transport TAP, oversampled in the clk_i domain.
//   tck/tms/tdi are synchronized into clk_i; a tck rise steps the 1149.1 TAP FSM and performs
//   capture/shift/update, a tck fall launches the next tdo bit. Instructions IDCODE (0x01),
//   DTMCS (0x10), DMIACCESS (0x11), BYPASS (0x1F and all others). A DMIACCESS Update-DR becomes
//   a valid/ready DMI request; the response is returned on the next DMIACCESS Capture-DR.
// Optional feature: define JTAG_TAP_TRST_EN to add the trst_ni port (active-low TAP reset).
// Ports:
//   clk_i, rst_i            system clock, asynchronous active-high reset
//   tck_i/tms_i/tdi_i       JTAG inputs, asynchronous to clk_i
//   trst_ni                 JTAG TRSTn (JTAG_TAP_TRST_EN only)
//   tdo_o, tdo_oe_o         JTAG data out and its enable (high in Shift-IR/Shift-DR)
//   dmi_req_*               DMI request channel (op 1=read, 2=write)
//   dmi_resp_*              DMI response channel (resp 0=ok, nonzero=error); ready tied high
//   tap_state_o             current TAP state, Test-Logic-Reset = 4'h0
module jtag_dmi_tap_sampled #(
  parameter logic [31:0] IDCODE      = 32'h249511C3,
  parameter int unsigned ABITS       = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tck_i,
  input  logic             tms_i,
  input  logic             tdi_i,
`ifdef JTAG_TAP_TRST_EN
  input  logic             trst_ni,
`endif
  output logic             tdo_o,
  output logic             tdo_oe_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [1:0]       dmi_req_op_o,
  output logic [31:0]      dmi_req_data_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_resp_i,
  output logic [3:0]       tap_state_o
);

  localparam int unsigned DmiW = ABITS + 34;
  localparam int unsigned IdxW = $clog2(DmiW);

  typedef enum logic [3:0] {
    StTlr = 4'h0, StRti = 4'h1, StSelDr = 4'h2, StCapDr = 4'h3,
    StShDr = 4'h4, StEx1Dr = 4'h5, StPauseDr = 4'h6, StEx2Dr = 4'h7,
    StUpdDr = 4'h8, StSelIr = 4'h9, StCapIr = 4'hA, StShIr = 4'hB,
    StEx1Ir = 4'hC, StPauseIr = 4'hD, StEx2Ir = 4'hE, StUpdIr = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {InsIdcode, InsDtmcs, InsDmi, InsBypass} ins_e;

  // Input synchronizers and tck edge detect
  logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
  logic                   tck_prev_q;
  logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;

  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;

`ifdef JTAG_TAP_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync_q;
  logic                   trst_s;
  assign trst_s = trst_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tck_sync_q  <= '0;
      tms_sync_q  <= '0;
      tdi_sync_q  <= '0;
      tck_prev_q  <= 1'b0;
`ifdef JTAG_TAP_TRST_EN
      trst_sync_q <= '0;
`endif
    end else begin
      tck_sync_q  <= {tck_sync_q[SYNC_STAGES-2:0], tck_i};
      tms_sync_q  <= {tms_sync_q[SYNC_STAGES-2:0], tms_i};
      tdi_sync_q  <= {tdi_sync_q[SYNC_STAGES-2:0], tdi_i};
      tck_prev_q  <= tck_s;
`ifdef JTAG_TAP_TRST_EN
      trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], trst_ni};
`endif
    end
  end

  tap_state_e       state_q, state_d, state_nxt;
  logic [4:0]       ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [DmiW-1:0]  dr_q, dr_d;
  logic             tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic             req_valid_q, req_valid_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
  logic [1:0]       req_op_q, req_op_d;
  logic [31:0]      req_data_q, req_data_d, resp_data_q, resp_data_d;
  logic             pend_q, pend_d;
  logic [1:0]       stat_q, stat_d, stat_resp;
  logic             resp_acc;
  ins_e             ins;
  logic [IdxW-1:0]  dr_msb;
  logic [31:0]      dtmcs_cap;
  logic [1:0]       dmi_op_cap;
  logic [ABITS-1:0] upd_addr;
  logic [31:0]      upd_data;
  logic [1:0]       upd_op;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      StTlr:     state_nxt = tms_s ? StTlr     : StRti;
      StRti:     state_nxt = tms_s ? StSelDr   : StRti;
      StSelDr:   state_nxt = tms_s ? StSelIr   : StCapDr;
      StCapDr:   state_nxt = tms_s ? StEx1Dr   : StShDr;
      StShDr:    state_nxt = tms_s ? StEx1Dr   : StShDr;
      StEx1Dr:   state_nxt = tms_s ? StUpdDr   : StPauseDr;
      StPauseDr: state_nxt = tms_s ? StEx2Dr   : StPauseDr;
      StEx2Dr:   state_nxt = tms_s ? StUpdDr   : StShDr;
      StUpdDr:   state_nxt = tms_s ? StSelDr   : StRti;
      StSelIr:   state_nxt = tms_s ? StTlr     : StCapIr;
      StCapIr:   state_nxt = tms_s ? StEx1Ir   : StShIr;
      StShIr:    state_nxt = tms_s ? StEx1Ir   : StShIr;
      StEx1Ir:   state_nxt = tms_s ? StUpdIr   : StPauseIr;
      StPauseIr: state_nxt = tms_s ? StEx2Ir   : StPauseIr;
      StEx2Ir:   state_nxt = tms_s ? StUpdIr   : StShIr;
      StUpdIr:   state_nxt = tms_s ? StSelDr   : StRti;
      default:   state_nxt = StTlr;
    endcase
  end

  always_comb begin
    unique case (ir_q)
      5'h01:   ins = InsIdcode;
      5'h10:   ins = InsDtmcs;
      5'h11:   ins = InsDmi;
      default: ins = InsBypass;
    endcase
    unique case (ins)
      InsIdcode, InsDtmcs: dr_msb = IdxW'(31);
      InsDmi:              dr_msb = IdxW'(DmiW - 1);
      default:             dr_msb = '0;
    endcase
  end

  assign resp_acc  = dmi_resp_valid_i & pend_q;
  assign upd_addr  = dr_q[DmiW-1 -: ABITS];
  assign upd_data  = dr_q[33:2];
  assign upd_op    = dr_q[1:0];
  assign dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, stat_q, 6'(ABITS), 4'd1};

  always_comb begin
    // A response landing this cycle is folded in first so a coincident capture sees it
    resp_data_d = resp_acc ? dmi_resp_data_i : resp_data_q;
    pend_d      = pend_q & ~resp_acc;
    stat_resp   = (resp_acc && dmi_resp_resp_i != 2'd0 && stat_q != 2'd3) ? 2'd2 : stat_q;
    stat_d      = stat_resp;
    dmi_op_cap  = pend_d ? 2'd3 : stat_resp;
    state_d     = state_q;
    ir_d        = ir_q;
    ir_shift_d  = ir_shift_q;
    dr_d        = dr_q;
    tdo_d       = tdo_q;
    req_valid_d = req_valid_q & ~dmi_req_ready_i;
    req_addr_d  = req_addr_q;
    req_op_d    = req_op_q;
    req_data_d  = req_data_q;
    last_addr_d = last_addr_q;

    if (tck_fall) begin
      tdo_d = (state_q inside {StCapIr, StShIr, StEx1Ir, StPauseIr, StEx2Ir, StUpdIr}) ?
              ir_shift_q[0] : dr_q[0];
    end

    if (tck_rise) begin
      state_d = state_nxt;
      unique case (state_q)
        StCapIr: ir_shift_d = 5'b00001;
        StShIr:  ir_shift_d = {tdi_s, ir_shift_q[4:1]};
        StUpdIr: ir_d = ir_shift_q;
        StCapDr: begin
          unique case (ins)
            InsIdcode: dr_d = DmiW'(IDCODE);
            InsDtmcs:  dr_d = DmiW'(dtmcs_cap);
            InsDmi:    dr_d = {last_addr_q, resp_data_d, dmi_op_cap};
            default:   dr_d = '0;
          endcase
          if (ins == InsDmi && pend_d) stat_d = 2'd3;
        end
        StShDr: begin
          dr_d         = dr_q >> 1;
          dr_d[dr_msb] = tdi_s;
        end
        StUpdDr: begin
          if (ins == InsDmi) begin
            if (pend_q) begin
              stat_d = 2'd3;
            end else if ((upd_op == 2'd1 || upd_op == 2'd2) && stat_q == 2'd0 && !req_valid_q) begin
              req_valid_d = 1'b1;
              req_addr_d  = upd_addr;
              req_op_d    = upd_op;
              req_data_d  = upd_data;
              last_addr_d = upd_addr;
              pend_d      = 1'b1;
            end
          end else if (ins == InsDtmcs) begin
            // dmihardreset also abandons the outstanding transaction
            if (dr_q[17]) begin
              stat_d = 2'd0;
              pend_d = 1'b0;
            end else if (dr_q[16]) begin
              stat_d = 2'd0;
            end
          end
        end
        default: ;
      endcase
    end

    if (state_q == StTlr) ir_d = 5'h01;

`ifdef JTAG_TAP_TRST_EN
    if (!trst_s) begin
      state_d     = StTlr;
      ir_d        = 5'h01;
      req_valid_d = 1'b0;
      pend_d      = 1'b0;
      stat_d      = 2'd0;
    end
`endif

    tdo_oe_d = (state_d == StShDr) || (state_d == StShIr);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StTlr;
      ir_q        <= 5'h01;
      ir_shift_q  <= '0;
      dr_q        <= '0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_op_q    <= '0;
      req_data_q  <= '0;
      last_addr_q <= '0;
      resp_data_q <= '0;
      pend_q      <= 1'b0;
      stat_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_shift_q  <= ir_shift_d;
      dr_q        <= dr_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_op_q    <= req_op_d;
      req_data_q  <= req_data_d;
      last_addr_q <= last_addr_d;
      resp_data_q <= resp_data_d;
      pend_q      <= pend_d;
      stat_q      <= stat_d;
    end
  end

  assign tdo_o            = tdo_q;
  assign tdo_oe_o         = tdo_oe_q;
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_addr_o   = req_addr_q;
  assign dmi_req_op_o     = req_op_q;
  assign dmi_req_data_o   = req_data_q;
  assign dmi_resp_ready_o = 1'b1;
  assign tap_state_o      = state_q;

endmodule
